ambilight_zone_avg: RTL and testbench

- Parametrised border-zone colour averager for the ambilight pipeline. Sits between the video timing/pixel stream and the LED data generator.
- Accumulates exact per-channel sums and pixel counts for every border zone (left column, top row, right column) over a configurable border depth.
- At frame end it snapshots the sums, divides them sequentially, and streams one averaged colour per zone over a valid/ready interface.
- Replaces running-average approximation with exact floor averages. Adds channel-count/width generality, backpressure and frame-drop accounting.

---
 rtl/ambilight_zone_avg_if.sv | 19 +
 rtl/ambilight_zone_avg.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ambilight_zone_avg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ambilight_zone_avg_if.sv
// Output stream of the ambilight zone averager: one averaged colour per zone
// with a valid/ready handshake.
//   m_valid  zone average valid (master -> slave)
//   m_ready  downstream accepts (slave -> master)
//   m_data   zone average, channel 0 in the LSBs
//   m_zone   zone index of m_data
//   m_last   high with the final zone of the frame
interface ambilight_zone_avg_if #(
  parameter int DATA_W = 24
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [7:0]        m_zone;
  logic              m_last;

  modport master (output m_valid, m_data, m_zone, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_zone, m_last, output m_ready);
endinterface

// File: rtl/ambilight_zone_avg.sv
// Border-zone colour averager for the ambilight pipeline.
// Accumulates exact per-channel sums and pixel counts for every border zone
// (left column bottom-to-top, top row left-to-right, right column
// top-to-bottom; corners belong to the shared corner zone). At frame end the
// sums are snapshotted, floor-divided one channel at a time by a shared
// restoring divider, and streamed out one zone per transfer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pix             pixel, channel 0 in the LSBs
//   h_cnt, v_cnt    column / line of pix
//   p_valid         pix/h_cnt/v_cnt valid this cycle
//   v_sync          high during vertical blanking
//   m               averaged zone stream (master side)
//   busy            divide/output in progress
//   drop_cnt        frames discarded while busy, saturating
module ambilight_zone_avg #(
  parameter int H_PIX  = 1920,
  parameter int V_PIX  = 1080,
  parameter int NUM_H  = 10,
  parameter int NUM_V  = 5,
  parameter int DEPTH  = 64,
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8,
  parameter int ACC_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] pix,
  input  logic [15:0]            h_cnt,
  input  logic [15:0]            v_cnt,
  input  logic                   p_valid,
  input  logic                   v_sync,
  ambilight_zone_avg_if.master   m,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int NUM_Z = NUM_H + 2 * NUM_V - 2;
  localparam int PH    = H_PIX / NUM_H;
  localparam int PV    = V_PIX / NUM_V;
  localparam int ZW    = $clog2(NUM_Z);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW    = $clog2(ACC_W + 2);
  // Largest zone: corner zone, widened by any remainder lines/columns that
  // the clamped zone indices fold into the last zone of a row or column.
  localparam int MAX_ZPIX = DEPTH * (PV + V_PIX % NUM_V) + (PH + H_PIX % NUM_H) * DEPTH;

  if (ACC_W < CH_W + $clog2(MAX_ZPIX)) begin : g_bad_acc_w
    $error("ACC_W too narrow for the largest zone sum");
  end
  if (DEPTH > PH || DEPTH > PV) begin : g_bad_depth
    $error("DEPTH exceeds the zone pitch");
  end

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Zone map
  // ---------------------------------------------------------------------
  logic [15:0]   hi, vi;
  logic          zone_hit;
  logic [ZW-1:0] zone_w;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hi       = h_cnt / 16'(PH);
    vi       = v_cnt / 16'(PV);
    zone_hit = 1'b0;
    zone_w   = '0;
    // Remainder pixels beyond the last full pitch join the last zone.
    if (hi > 16'(NUM_H - 1)) hi = 16'(NUM_H - 1);
    if (vi > 16'(NUM_V - 1)) vi = 16'(NUM_V - 1);
    if (p_valid && h_cnt < 16'(H_PIX) && v_cnt < 16'(V_PIX)) begin
      if (h_cnt < 16'(DEPTH)) begin
        zone_hit = 1'b1;
        zone_w   = ZW'(16'(NUM_V - 1) - vi);
      end else if (v_cnt < 16'(DEPTH)) begin
        zone_hit = 1'b1;
        zone_w   = ZW'(16'(NUM_V - 1) + hi);
      end else if (h_cnt >= 16'(H_PIX - DEPTH)) begin
        zone_hit = 1'b1;
        zone_w   = ZW'(16'(NUM_V + NUM_H - 2) + vi);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame edges: v_sync is registered twice, edges seen between the stages.
  // Frame end is delayed two more cycles so the accumulate pipe drains.
  // ---------------------------------------------------------------------
  logic vs_q, vs_q2, end_d1, end_d2;
  logic frame_start, frame_end;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset as if in blanking so leaving reset never fakes a frame end.
      vs_q   <= 1'b1;
      vs_q2  <= 1'b1;
      end_d1 <= 1'b0;
      end_d2 <= 1'b0;
    end else begin
      vs_q   <= v_sync;
      vs_q2  <= vs_q;
      end_d1 <= vs_q & ~vs_q2;
      end_d2 <= end_d1;
    end
  end

  assign frame_start = vs_q2 & ~vs_q;
  assign frame_end   = end_d2;

  // ---------------------------------------------------------------------
  // Accumulate pipeline
  // ---------------------------------------------------------------------
  logic                   s1_valid;
  logic [ZW-1:0]          s1_zone;
  logic [NUM_CH*CH_W-1:0] s1_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_zone  <= '0;
      s1_pix   <= '0;
    end else begin
      s1_valid <= zone_hit;
      s1_zone  <= zone_w;
      s1_pix   <= pix;
    end
  end

  logic [ACC_W-1:0] sum_q    [NUM_Z][NUM_CH];
  logic [ACC_W-1:0] cnt_q    [NUM_Z];
  logic [ACC_W-1:0] snap_sum [NUM_Z][NUM_CH];
  logic [ACC_W-1:0] snap_cnt [NUM_Z];

  // Read-modify-write in one cycle, so back-to-back hits on one zone
  // always see the previous update.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator arrays are reset explicitly; an unknown sum
    // after reset would otherwise reach the output if a frame ends before
    // any frame start has cleared them.
    if (rst || frame_start) begin
      for (int z = 0; z < NUM_Z; z++) begin
        cnt_q[z] <= '0;
        for (int c = 0; c < NUM_CH; c++) sum_q[z][c] <= '0;
      end
    end else if (s1_valid) begin
      cnt_q[s1_zone] <= cnt_q[s1_zone] + ACC_W'(1);
      for (int c = 0; c < NUM_CH; c++)
        sum_q[s1_zone][c] <= sum_q[s1_zone][c] + ACC_W'(s1_pix[c*CH_W +: CH_W]);
    end
  end

  // ---------------------------------------------------------------------
  // Divide / output FSM
  // ---------------------------------------------------------------------
  logic [ZW-1:0]    zone_q;
  logic [CW-1:0]    ch_q;
  logic [SW-1:0]    step_q;
  logic [ACC_W-1:0] div_rem, div_quo;
  logic [ACC_W:0]   div_shift, div_diff;
  logic [CH_W-1:0]  res_q [NUM_CH];
  logic [ACC_W-1:0] cur_cnt, cur_sum;
  logic             ch_last, step_last, zone_last;

  assign cur_cnt   = snap_cnt[zone_q];
  assign cur_sum   = snap_sum[zone_q][ch_q];
  assign ch_last   = (ch_q == CW'(NUM_CH - 1));
  assign step_last = (step_q == SW'(ACC_W + 1));
  assign zone_last = (zone_q == ZW'(NUM_Z - 1));

  // One restoring step: shift in the next dividend bit and subtract when the
  // partial remainder allows. Sign of the ACC_W+1-bit difference decides.
  always_comb begin
    div_shift = {div_rem, div_quo[ACC_W-1]};
    div_diff  = div_shift - {1'b0, cur_cnt};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_end) state_d = S_DIV;
      S_DIV:   if (ch_last && step_last) state_d = S_OUT;
      S_OUT:   if (m.m_ready) state_d = zone_last ? S_IDLE : S_DIV;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_q   <= '0;
      ch_q     <= '0;
      step_q   <= '0;
      div_rem  <= '0;
      div_quo  <= '0;
      drop_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) res_q[c] <= '0;
      for (int z = 0; z < NUM_Z; z++) begin
        snap_cnt[z] <= '0;
        for (int c = 0; c < NUM_CH; c++) snap_sum[z][c] <= '0;
      end
    end else begin
      // A frame ending while the previous one is still in flight is lost;
      // the snapshot and output stay untouched.
      if (frame_end && state_q != S_IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (frame_end) begin
            snap_sum <= sum_q;
            snap_cnt <= cnt_q;
            zone_q   <= '0;
            ch_q     <= '0;
            step_q   <= '0;
          end
        end
        S_DIV: begin
          if (step_q == '0) begin
            div_rem <= '0;
            div_quo <= cur_sum;
            step_q  <= step_q + SW'(1);
          end else if (!step_last) begin
            if (!div_diff[ACC_W]) begin
              div_rem <= div_diff[ACC_W-1:0];
              div_quo <= {div_quo[ACC_W-2:0], 1'b1};
            end else begin
              div_rem <= div_shift[ACC_W-1:0];
              div_quo <= {div_quo[ACC_W-2:0], 1'b0};
            end
            step_q <= step_q + SW'(1);
          end else begin
            // An average of CH_W-bit samples always fits in CH_W bits.
            res_q[ch_q] <= (cur_cnt == '0) ? '0 : div_quo[CH_W-1:0];
            step_q      <= '0;
            ch_q        <= ch_last ? '0 : ch_q + CW'(1);
          end
        end
        S_OUT: begin
          if (m.m_ready && !zone_last) zone_q <= zone_q + ZW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers only change in DIV, so the output holds under stall.
  always_comb begin
    m.m_data = '0;
    for (int c = 0; c < NUM_CH; c++) m.m_data[c*CH_W +: CH_W] = res_q[c];
  end

  assign m.m_valid = (state_q == S_OUT);
  assign m.m_zone  = 8'(zone_q);
  assign m.m_last  = zone_last;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ambilight_zone_avg.sv
// Directed bench for ambilight_zone_avg on a 40x20 frame, 4x2 zones, depth 4.
// Zone geometry (PH=PV=10): z0 left h<4 v>=10; z1 left h<4 v<10 plus top
// h4..9 v<4; z2 top h10..19; z3 top h20..29; z4 top h30..35 plus right
// h36..39 v<10; z5 right h36..39 v>=10.
module tb_ambilight_zone_avg;

  localparam int H = 40, V = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pix;
  logic [15:0] h_cnt, v_cnt;
  logic        p_valid, v_sync;
  logic        busy;
  logic [7:0]  drop_cnt;

  ambilight_zone_avg_if #(.DATA_W(24)) m_if ();

  ambilight_zone_avg #(
    .H_PIX(40), .V_PIX(20), .NUM_H(4), .NUM_V(2), .DEPTH(4),
    .NUM_CH(3), .CH_W(8), .ACC_W(24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix      (pix),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .p_valid  (p_valid),
    .v_sync   (v_sync),
    .m        (m_if),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_z [6];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // mode 0 uniform, 1 floor test, 2 gradient, 3 gradient with the first
  // zone column (h < 10, i.e. all of zones 0 and 1) not valid.
  function automatic logic [23:0] pix_of(input int mode, input int h, input int v);
    logic [23:0] p;
    case (mode)
      0: p = 24'h102030;
      1: begin
        if (h < 4 && v >= 10)                   p = ((h + v) % 2 == 1) ? 24'h00000D : 24'h00000A;
        else if (h >= 4 && h < 36 && v >= 4)    p = 24'hFFFFFF;
        else                                    p = 24'h102030;
      end
      default: p = {8'h55, 8'(v), 8'(h)};
    endcase
    return p;
  endfunction

  // Hand-computed floor averages per zone.
  task automatic load_exp(input int mode);
    case (mode)
      0: for (int z = 0; z < 6; z++) exp_z[z] = 24'h102030;
      1: begin
        for (int z = 0; z < 6; z++) exp_z[z] = 24'h102030;
        exp_z[0] = 24'h00000B;                      // 20*10 + 20*13 = 460, /40 = 11
      end
      default: begin
        exp_z[0] = 24'h550E01; exp_z[1] = 24'h550303; exp_z[2] = 24'h55010E;
        exp_z[3] = 24'h550118; exp_z[4] = 24'h550323; exp_z[5] = 24'h550E25;
        if (mode == 3) begin
          exp_z[0] = 24'h000000;
          exp_z[1] = 24'h000000;
        end
      end
    endcase
  endtask

  task automatic send_frame(input int mode);
    v_sync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        h_cnt   = 16'(h);
        v_cnt   = 16'(v);
        pix     = pix_of(mode, h, v);
        p_valid = (mode == 3) ? (h >= 10) : 1'b1;
        @(posedge clk);
        #1;
      end
    end
    p_valid = 1'b0;
    v_sync  = 1'b1;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!m_if.m_valid && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("valid_wait", 32'(m_if.m_valid), 32'd1);
  endtask

  // Accepts n zones starting at zone 0, stalling stall_zone for 50 cycles.
  task automatic collect(input int n, input int stall_zone);
    logic        stable;
    logic [23:0] d0;
    for (int z = 0; z < n; z++) begin
      wait_valid();
      check($sformatf("zone%0d_idx", z),  32'(m_if.m_zone), 32'(z));
      check($sformatf("zone%0d_data", z), 32'(m_if.m_data), 32'(exp_z[z]));
      check($sformatf("zone%0d_last", z), 32'(m_if.m_last), 32'(z == 5));
      if (z == stall_zone) begin
        stable = 1'b1;
        d0     = m_if.m_data;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk);
          #1;
          if (!m_if.m_valid || m_if.m_data !== d0 || m_if.m_zone !== 8'(z)) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
      end
      m_if.m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_if.m_ready = 1'b0;
      if (z == 5) check("busy_after_last", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; pix = '0; h_cnt = '0; v_cnt = '0;
    p_valid = 1'b0; v_sync = 1'b1; m_if.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_drop",  32'(drop_cnt),     32'd0);
    check("rst_data",  32'(m_if.m_data),  32'd0);
    check("rst_zone",  32'(m_if.m_zone),  32'd0);
    check("rst_last",  32'(m_if.m_last),  32'd0);

    // Uniform frame.
    send_frame(0); load_exp(0); collect(6, -1);

    // Floor division with bright interior that must not leak into any zone.
    send_frame(1); load_exp(1); collect(6, -1);

    // Distinct per-zone averages with a 50-cycle stall on zone 2.
    send_frame(2); load_exp(2); collect(6, 2);

    // Frame drop: frame A is stuck in OUT while frame B arrives and ends.
    send_frame(2);
    wait_valid();
    send_frame(0);
    repeat (5) @(posedge clk);
    #1;
    check("drop_cnt_1",  32'(drop_cnt),     32'd1);
    check("drop_held_v", 32'(m_if.m_valid), 32'd1);
    check("drop_held_z", 32'(m_if.m_zone),  32'd0);
    load_exp(2); collect(6, -1);
    send_frame(0); load_exp(0); collect(6, -1);
    check("drop_cnt_keep", 32'(drop_cnt), 32'd1);

    // Empty zones 0 and 1.
    send_frame(3); load_exp(3); collect(6, -1);

    // Reset while zone 3 is being offered.
    send_frame(2); load_exp(2); collect(3, -1);
    wait_valid();
    check("pre_rst_zone", 32'(m_if.m_zone), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),         32'd0);
    check("mid_rst_drop",  32'(drop_cnt),     32'd0);
    send_frame(2); load_exp(2); collect(6, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
